// File: rtl/router_input_port_pkg.sv
// Shared constants and types for the mesh router input stage.
package router_input_port_pkg;

    // Output port indices, also the bit positions of the one-hot request.
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 4;
    localparam int PACKET_W  = 32;
    localparam int FLITS     = PACKET_W / FLIT_W;

    // Input stage phases: gather a whole packet, then stream it out.
    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

endpackage

// File: rtl/xy_route_compute.sv
// Dimension-order (X first, then Y) route decision for one packet header.
module xy_route_compute
    import router_input_port_pkg::*;
(
    input  logic [3:0]           dx,
    input  logic [3:0]           dy,
    input  logic [3:0]           x,
    input  logic [3:0]           y,
    output logic [2:0]           port,
    output logic [NUM_PORTS-1:0] onehot
);

    // Resolve X before Y; a packet only turns north/south once its column matches.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        port   = PORT_LOCAL;
        onehot = '0;
        if (dx > x) begin
            port = PORT_EAST;
        end else if (dx < x) begin
            port = PORT_WEST;
        end else if (dy > y) begin
            port = PORT_NORTH;
        end else if (dy < y) begin
            port = PORT_SOUTH;
        end
        onehot[port] = 1'b1;
    end

endmodule

// File: rtl/router_input_port.sv
// Per-direction router input stage: buffers one packet from the input FIFO,
// routes it XY, requests an output and streams its flits to the crossbar.
module router_input_port
    import router_input_port_pkg::*;
#(
    parameter int X_COORDINATE = 1,
    parameter int Y_COORDINATE = 1,
    parameter int flit_size    = FLIT_W,
    parameter int packet_size  = PACKET_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [flit_size-1:0] flit_in,
    input  logic                 stall,
    input  logic [NUM_PORTS-1:0] destination_full_vector,
    output logic                 read_fifo,
    output logic [flit_size-1:0] flit_out,
    output logic [2:0]           destination_port,
    output logic                 current_address_ready,
    output logic [NUM_PORTS-1:0] request_vector
);

    localparam int NFLITS = packet_size / flit_size;
    localparam int IDX_W  = $clog2(NFLITS);
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NFLITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFLITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFLITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       rd_cnt;
    logic [CNT_W-1:0]       cap_cnt;
    logic [IDX_W-1:0]       idx;
    logic                   rd_valid;
    logic [packet_size-1:0] packet;

    logic [2:0]             route_port;
    logic [NUM_PORTS-1:0]   route_onehot;
    logic                   xfer;

    // Route is taken from the buffered header, so it cannot change mid-packet.
    xy_route_compute u_route (
        .dx     (packet[3:0]),
        .dy     (packet[7:4]),
        .x      (4'(X_COORDINATE)),
        .y      (4'(Y_COORDINATE)),
        .port   (route_port),
        .onehot (route_onehot)
    );

    // Pop the FIFO while collecting and fewer than a packet's worth has been requested.
    assign read_fifo = !reset && (state == COLLECT) && !fifo_empty && (rd_cnt < CNT_FULL);

    // A flit moves only when some request survives the full mask and an arbiter granted us.
    assign xfer = (state == SEND) && (request_vector != '0) && !stall;

    // Crossbar-facing outputs are driven only while a packet is being sent.
    always_comb begin
        flit_out              = '0;
        destination_port      = PORT_LOCAL;
        current_address_ready = 1'b0;
        request_vector        = '0;
        if (state == SEND) begin
            flit_out              = packet[flit_size*idx +: flit_size];
            destination_port      = route_port;
            current_address_ready = 1'b1;
            request_vector        = route_onehot & ~destination_full_vector;
        end
    end

    // Collect/send sequencing, read and capture counters, and the packet buffer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
        if (reset) begin
            state    <= COLLECT;
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            idx      <= '0;
            rd_valid <= 1'b0;
            packet   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    rd_valid <= read_fifo;
                    if (read_fifo) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    // FIFO data lags the read strobe by one cycle.
                    if (rd_valid) begin
                        packet[flit_size*cap_cnt[IDX_W-1:0] +: flit_size] <= flit_in;
                        cap_cnt <= cap_cnt + 1'b1;
                        if (cap_cnt == CNT_LAST) begin
                            state <= SEND;
                            idx   <= '0;
                        end
                    end
                end
                SEND: begin
                    rd_valid <= 1'b0;
                    if (xfer) begin
                        if (idx == IDX_LAST) begin
                            state   <= COLLECT;
                            rd_cnt  <= '0;
                            cap_cnt <= '0;
                            idx     <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// Directed self-checking bench for router_input_port at router (1,1).
module tb_router_input_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [3:0] flit_in = '0;
    logic       stall;
    logic [4:0] destination_full_vector;
    logic       read_fifo;
    logic [3:0] flit_out;
    logic [2:0] destination_port;
    logic       current_address_ready;
    logic [4:0] request_vector;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Simple FIFO model: flits pushed by the stimulus, popped by read_fifo.
    logic [3:0] mem [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    logic       force_empty = 1'b0;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (read_fifo) begin
            flit_in <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end
    end

    always #5 clk = ~clk;

    router_input_port #(
        .X_COORDINATE (1),
        .Y_COORDINATE (1),
        .flit_size    (4),
        .packet_size  (32)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .fifo_empty              (fifo_empty),
        .flit_in                 (flit_in),
        .stall                   (stall),
        .destination_full_vector (destination_full_vector),
        .read_fifo               (read_fifo),
        .flit_out                (flit_out),
        .destination_port        (destination_port),
        .current_address_ready   (current_address_ready),
        .request_vector          (request_vector)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [31:0] p);
        for (int i = 0; i < 8; i++) begin
            mem[wr_ptr] = p[4*i +: 4];
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    // Reset with the packet already in the FIFO; returns in cycle 0.
    task automatic start(input logic [31:0] p);
        reset = 1'b1;
        push(p);
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    function automatic logic [3:0] nib(input logic [31:0] p, input int i);
        return p[4*i +: 4];
    endfunction

    // Run a packet with no stall or full and check the route and one flit window.
    task automatic route_case(input logic [31:0] p, input logic [2:0] port, input logic [4:0] req);
        start(p);
        for (int c = 1; c <= 17; c++) begin
            tick();
            #1;
            if (c == 9) begin
                check("route_port", 32'(destination_port), 32'(port));
                check("route_req", 32'(request_vector), 32'(req));
            end
            if (c == 17) check("route_done_req", 32'(request_vector), 32'd0);
        end
    endtask

    logic [31:0] p;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        destination_full_vector = '0;

        // Reset state with data waiting in the FIFO.
        p = 32'hDCBA_9821;
        push(p);
        tick();
        tick();
        #1;
        check("rst_read_fifo", 32'(read_fifo), 32'd0);
        check("rst_flit_out", 32'(flit_out), 32'd0);
        check("rst_port", 32'(destination_port), 32'd0);
        check("rst_ready", 32'(current_address_ready), 32'd0);
        check("rst_req", 32'(request_vector), 32'd0);

        // Basic packet: north route, flits streamed cycles 9..16.
        reset = 1'b0;
        cyc   = 0;
        #1;
        check("p1_read", 32'(read_fifo), 32'd1);
        for (int c = 1; c <= 17; c++) begin
            tick();
            #1;
            if (c <= 7) check("p1_read", 32'(read_fifo), 32'd1);
            if (c == 8) begin
                check("p1_read_stop", 32'(read_fifo), 32'd0);
                check("p1_ready_early", 32'(current_address_ready), 32'd0);
            end
            if (c == 9) begin
                check("p1_port", 32'(destination_port), 32'd1);
                check("p1_req", 32'(request_vector), 32'b00010);
                check("p1_ready", 32'(current_address_ready), 32'd1);
            end
            if (c >= 9 && c <= 16) check("p1_flit", 32'(flit_out), 32'(nib(p, c - 9)));
            if (c == 17) begin
                check("p1_done_req", 32'(request_vector), 32'd0);
                check("p1_done_ready", 32'(current_address_ready), 32'd0);
                check("p1_done_flit", 32'(flit_out), 32'd0);
            end
        end

        // Route table at (1,1).
        route_case(32'h1234_5603, 3'd3, 5'b01000);
        route_case(32'hFEDC_BA20, 3'd4, 5'b10000);
        route_case(32'h0F0F_0F11, 3'd0, 5'b00001);
        route_case(32'hA5A5_5A01, 3'd2, 5'b00100);

        // Stall during cycles 9..11 holds flit 0.
        p = 32'hDCBA_9821;
        start(p);
        for (int c = 1; c <= 20; c++) begin
            tick();
            stall = (c >= 9 && c <= 11);
            #1;
            if (c >= 9 && c <= 11) check("stall_hold", 32'(flit_out), 32'h1);
            if (c >= 12 && c <= 19) check("stall_flit", 32'(flit_out), 32'(nib(p, c - 12)));
            if (c == 20) check("stall_done_req", 32'(request_vector), 32'd0);
        end
        stall = 1'b0;

        // North output full during cycles 11..13.
        start(p);
        for (int c = 1; c <= 20; c++) begin
            tick();
            destination_full_vector = (c >= 11 && c <= 13) ? 5'b00010 : 5'b00000;
            #1;
            if (c == 9 || c == 10) check("full_pre", 32'(flit_out), 32'(nib(p, c - 9)));
            if (c >= 11 && c <= 13) begin
                check("full_req", 32'(request_vector), 32'd0);
                check("full_hold", 32'(flit_out), 32'h8);
            end
            if (c >= 14 && c <= 19) check("full_flit", 32'(flit_out), 32'(nib(p, c - 12)));
            if (c == 20) check("full_done_req", 32'(request_vector), 32'd0);
        end
        destination_full_vector = '0;

        // FIFO empty for 3 cycles after 4 reads: SEND delayed to cycle 12.
        p = 32'h7E5D_4C21;
        start(p);
        #1;
        check("gap_read", 32'(read_fifo), 32'd1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            force_empty = (c >= 4 && c <= 6);
            #1;
            if (c <= 10) check("gap_read", 32'(read_fifo), 32'((c <= 3 || c >= 7) ? 1 : 0));
            if (c == 11) check("gap_ready_early", 32'(current_address_ready), 32'd0);
            if (c == 12) begin
                check("gap_ready", 32'(current_address_ready), 32'd1);
                check("gap_port", 32'(destination_port), 32'd1);
            end
            if (c >= 12 && c <= 19) check("gap_flit", 32'(flit_out), 32'(nib(p, c - 12)));
        end
        force_empty = 1'b0;

        // Reset while flit 4 is on the output.
        p = 32'hDCBA_9821;
        start(p);
        for (int c = 1; c <= 13; c++) begin
            tick();
            #1;
            if (c == 13) check("mid_flit4", 32'(flit_out), 32'hA);
        end
        reset = 1'b1;
        tick();
        #1;
        check("mid_rst_flit", 32'(flit_out), 32'd0);
        check("mid_rst_req", 32'(request_vector), 32'd0);
        check("mid_rst_ready", 32'(current_address_ready), 32'd0);
        check("mid_rst_port", 32'(destination_port), 32'd0);
        check("mid_rst_read", 32'(read_fifo), 32'd0);
        p = 32'h3456_7803;
        start(p);
        for (int c = 1; c <= 17; c++) begin
            tick();
            #1;
            if (c == 9) begin
                check("after_port", 32'(destination_port), 32'd3);
                check("after_req", 32'(request_vector), 32'b01000);
            end
            if (c >= 9 && c <= 16) check("after_flit", 32'(flit_out), 32'(nib(p, c - 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
